// File: rtl/reg_writeback_stage.sv
// MEM/WB pipeline register and register-file write-back driver for the 16-bit CPU.
// Also bypasses the pending write-back to decode, counts retirements and flags illegal selects.
module reg_writeback_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 3
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic [OP_W-1:0]   mem_reg_op,
  input  logic [ADDR_W-1:0] mem_wb_addr,
  input  logic [1:0]        mem_wb_sel,
  input  logic [DATA_W-1:0] mem_alu_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic [DATA_W-1:0] mem_pc_next,
  input  logic [ADDR_W-1:0] dec_A_addr,
  input  logic [ADDR_W-1:0] dec_B_addr,
  input  logic [DATA_W-1:0] rf_A_data,
  input  logic [DATA_W-1:0] rf_B_data,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [OP_W-1:0]   reg_op,
  output logic [DATA_W-1:0] A_fwd_data,
  output logic [DATA_W-1:0] B_fwd_data,
  output logic              fwd_A_hit,
  output logic              fwd_B_hit,
  output logic [15:0]       retire_cnt,
  output logic              sel_err
);

  localparam logic [OP_W-1:0] REG_OP_NOP = OP_W'(0);
  localparam logic [OP_W-1:0] REG_OP_REG = OP_W'(1);

  typedef enum logic [1:0] {
    SEL_ALU = 2'b00,
    SEL_MEM = 2'b01,
    SEL_PC  = 2'b10,
    SEL_ILL = 2'b11
  } wb_sel_e;

  logic              wb_valid_q,   wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q,    wb_addr_d;
  logic [DATA_W-1:0] wb_data_q,    wb_data_d;
  logic [OP_W-1:0]   reg_op_q,     reg_op_d;
  logic [15:0]       retire_cnt_q, retire_cnt_d;
  logic              sel_err_q,    sel_err_d;

  logic              capture;
  logic [DATA_W-1:0] sel_data;

  assign capture = !flush && !stall;

  always_comb begin
    sel_data = mem_alu_data;
    unique case (wb_sel_e'(mem_wb_sel))
      SEL_MEM: sel_data = mem_rd_data;
      SEL_PC:  sel_data = mem_pc_next;
      default: sel_data = mem_alu_data;  // illegal select falls back to the ALU result
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    wb_valid_d   = wb_valid_q;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    reg_op_d     = reg_op_q;
    retire_cnt_d = retire_cnt_q;
    sel_err_d    = sel_err_q;

    if (flush) begin
      wb_valid_d = 1'b0;
      reg_op_d   = REG_OP_NOP;
    end else if (!stall) begin
      wb_valid_d = mem_valid;
      reg_op_d   = mem_valid ? mem_reg_op : REG_OP_NOP;
      wb_addr_d  = mem_wb_addr;
      wb_data_d  = sel_data;
    end

    // The current entry retires when it leaves WB, so a held entry is counted once.
    if (wb_valid_q && (!stall || flush)) retire_cnt_d = retire_cnt_q + 16'd1;

    if (capture && mem_valid && (mem_wb_sel == SEL_ILL)) sel_err_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      reg_op_q     <= REG_OP_NOP;
      retire_cnt_q <= '0;
      sel_err_q    <= 1'b0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      reg_op_q     <= reg_op_d;
      retire_cnt_q <= retire_cnt_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign reg_op     = reg_op_q;
  assign retire_cnt = retire_cnt_q;
  assign sel_err    = sel_err_q;

  assign fwd_A_hit  = wb_valid_q && (reg_op_q == REG_OP_REG) && (dec_A_addr == wb_addr_q);
  assign fwd_B_hit  = wb_valid_q && (reg_op_q == REG_OP_REG) && (dec_B_addr == wb_addr_q);
  assign A_fwd_data = fwd_A_hit ? wb_data_q : rf_A_data;
  assign B_fwd_data = fwd_B_hit ? wb_data_q : rf_B_data;

endmodule

// File: tb/tb_reg_writeback_stage.sv
// Directed bench for reg_writeback_stage: capture, bypass, stall/flush, counter wrap,
// sticky select error and asynchronous reset.
module tb_reg_writeback_stage;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_REG = 3'd1;
  localparam logic [2:0] OP_RA  = 3'd5;

  logic        clk_50MHz = 1'b0;
  logic        rst, stall, flush, mem_valid;
  logic [2:0]  mem_reg_op, mem_wb_addr, dec_A_addr, dec_B_addr;
  logic [1:0]  mem_wb_sel;
  logic [15:0] mem_alu_data, mem_rd_data, mem_pc_next, rf_A_data, rf_B_data;
  logic        wb_valid, fwd_A_hit, fwd_B_hit, sel_err;
  logic [2:0]  wb_addr, reg_op;
  logic [15:0] wb_data, A_fwd_data, B_fwd_data, retire_cnt;

  int checks   = 0;
  int failures = 0;

  always #10 clk_50MHz = ~clk_50MHz;

  reg_writeback_stage dut (
    .clk_50MHz   (clk_50MHz),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .mem_valid   (mem_valid),
    .mem_reg_op  (mem_reg_op),
    .mem_wb_addr (mem_wb_addr),
    .mem_wb_sel  (mem_wb_sel),
    .mem_alu_data(mem_alu_data),
    .mem_rd_data (mem_rd_data),
    .mem_pc_next (mem_pc_next),
    .dec_A_addr  (dec_A_addr),
    .dec_B_addr  (dec_B_addr),
    .rf_A_data   (rf_A_data),
    .rf_B_data   (rf_B_data),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .reg_op      (reg_op),
    .A_fwd_data  (A_fwd_data),
    .B_fwd_data  (B_fwd_data),
    .fwd_A_hit   (fwd_A_hit),
    .fwd_B_hit   (fwd_B_hit),
    .retire_cnt  (retire_cnt),
    .sel_err     (sel_err)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic drive_mem(input logic v, input logic [2:0] op, input logic [2:0] addr,
                           input logic [1:0] sel, input logic [15:0] alu,
                           input logic [15:0] rd, input logic [15:0] pc);
    mem_valid    = v;
    mem_reg_op   = op;
    mem_wb_addr  = addr;
    mem_wb_sel   = sel;
    mem_alu_data = alu;
    mem_rd_data  = rd;
    mem_pc_next  = pc;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drive_mem(1'b1, OP_REG, 3'd7, 2'b00, 16'h7777, 16'h0, 16'h0);
    dec_A_addr = 3'd0; dec_B_addr = 3'd0; rf_A_data = 16'hAAAA; rf_B_data = 16'hBBBB;

    #5;
    check("rst_valid",  {31'd0, wb_valid}, 32'd0);
    check("rst_reg_op", {29'd0, reg_op},   {29'd0, OP_NOP});
    check("rst_addr",   {29'd0, wb_addr},  32'd0);
    check("rst_data",   {16'd0, wb_data},  32'd0);
    check("rst_retire", {16'd0, retire_cnt}, 32'd0);
    check("rst_selerr", {31'd0, sel_err},  32'd0);

    // Held in reset across an edge with a valid incoming instruction.
    step();
    check("rst_hold_valid", {31'd0, wb_valid}, 32'd0);
    rst = 1'b1;

    // Memory-read write-back to R3 with bypass on A only.
    drive_mem(1'b1, OP_REG, 3'd3, 2'b01, 16'h5555, 16'h1234, 16'h0777);
    dec_A_addr = 3'd3; dec_B_addr = 3'd2;
    step();
    check("c1_valid",  {31'd0, wb_valid},   32'd1);
    check("c1_addr",   {29'd0, wb_addr},    32'd3);
    check("c1_data",   {16'd0, wb_data},    32'h1234);
    check("c1_reg_op", {29'd0, reg_op},     {29'd0, OP_REG});
    check("c1_hitA",   {31'd0, fwd_A_hit},  32'd1);
    check("c1_fwdA",   {16'd0, A_fwd_data}, 32'h1234);
    check("c1_hitB",   {31'd0, fwd_B_hit},  32'd0);
    check("c1_fwdB",   {16'd0, B_fwd_data}, 32'hBBBB);
    check("c1_retire", {16'd0, retire_cnt}, 32'd0);

    // Link write to RA: never a bypass hit even with matching addresses.
    drive_mem(1'b1, OP_RA, 3'd3, 2'b10, 16'h5555, 16'h1234, 16'h00A1);
    dec_B_addr = 3'd3;
    step();
    check("c2_data",   {16'd0, wb_data},    32'h00A1);
    check("c2_reg_op", {29'd0, reg_op},     {29'd0, OP_RA});
    check("c2_hitA",   {31'd0, fwd_A_hit},  32'd0);
    check("c2_hitB",   {31'd0, fwd_B_hit},  32'd0);
    check("c2_fwdA",   {16'd0, A_fwd_data}, 32'hAAAA);
    check("c2_fwdB",   {16'd0, B_fwd_data}, 32'hBBBB);
    check("c2_retire", {16'd0, retire_cnt}, 32'd1);

    // ALU write to R5, then stall three cycles while the inputs change.
    drive_mem(1'b1, OP_REG, 3'd5, 2'b00, 16'h0BEE, 16'h0, 16'h0);
    step();
    check("c3_data",   {16'd0, wb_data},    32'h0BEE);
    check("c3_retire", {16'd0, retire_cnt}, 32'd2);
    stall = 1'b1;
    drive_mem(1'b1, OP_REG, 3'd6, 2'b00, 16'hDEAD, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid",  {31'd0, wb_valid},   32'd1);
      check("stall_addr",   {29'd0, wb_addr},    32'd5);
      check("stall_data",   {16'd0, wb_data},    32'h0BEE);
      check("stall_retire", {16'd0, retire_cnt}, 32'd2);
    end
    stall = 1'b0;
    mem_valid = 1'b0;
    step();
    check("unstall_retire", {16'd0, retire_cnt}, 32'd3);
    check("unstall_valid",  {31'd0, wb_valid},   32'd0);
    check("unstall_reg_op", {29'd0, reg_op},     {29'd0, OP_NOP});
    step();
    check("idle_retire", {16'd0, retire_cnt}, 32'd3);

    // Flush and stall together with a valid incoming instruction: flush wins.
    drive_mem(1'b1, OP_REG, 3'd1, 2'b00, 16'h1111, 16'h0, 16'h0);
    step();
    check("pre_flush_valid", {31'd0, wb_valid}, 32'd1);
    flush = 1'b1; stall = 1'b1;
    drive_mem(1'b1, OP_REG, 3'd2, 2'b00, 16'h2222, 16'h0, 16'h0);
    step();
    check("flush_valid",  {31'd0, wb_valid},   32'd0);
    check("flush_reg_op", {29'd0, reg_op},     {29'd0, OP_NOP});
    check("flush_addr",   {29'd0, wb_addr},    32'd1);
    check("flush_data",   {16'd0, wb_data},    32'h1111);
    check("flush_retire", {16'd0, retire_cnt}, 32'd4);
    check("flush_selerr", {31'd0, sel_err},    32'd0);
    flush = 1'b0; stall = 1'b0;

    // Illegal select falls back to ALU data and sets the sticky flag.
    drive_mem(1'b1, OP_REG, 3'd4, 2'b11, 16'h4242, 16'h9999, 16'h8888);
    step();
    check("ill_data",   {16'd0, wb_data},    32'h4242);
    check("ill_selerr", {31'd0, sel_err},    32'd1);
    check("ill_retire", {16'd0, retire_cnt}, 32'd4);

    // Retire continuously up to 0xFFFF, then wrap.
    drive_mem(1'b1, OP_REG, 3'd4, 2'b00, 16'h0042, 16'h0, 16'h0);
    for (int i = 0; i < 65531; i++) step();
    check("wrap_max",    {16'd0, retire_cnt}, 32'hFFFF);
    step();
    check("wrap_zero",   {16'd0, retire_cnt}, 32'h0000);
    check("wrap_selerr", {31'd0, sel_err},    32'd1);
    check("wrap_valid",  {31'd0, wb_valid},   32'd1);

    // Asynchronous reset in the middle of a cycle.
    #5;
    rst = 1'b0;
    #1;
    check("arst_valid",  {31'd0, wb_valid},   32'd0);
    check("arst_reg_op", {29'd0, reg_op},     {29'd0, OP_NOP});
    check("arst_addr",   {29'd0, wb_addr},    32'd0);
    check("arst_data",   {16'd0, wb_data},    32'd0);
    check("arst_retire", {16'd0, retire_cnt}, 32'd0);
    check("arst_selerr", {31'd0, sel_err},    32'd0);
    check("arst_hitA",   {31'd0, fwd_A_hit},  32'd0);
    step();
    check("arst_hold_valid", {31'd0, wb_valid}, 32'd0);
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_writeback_stage.md
Name: reg_writeback_stage

Overview:
- MEM/WB pipeline register and write-back driver for the 16-bit CPU register file.
- Captures the instruction leaving the memory stage and selects the write-back source (ALU result, memory read data or PC+1).
- Presents wb_addr / wb_data / reg_op to the register file, which commits on the following negedge.
- Provides a combinational bypass so decode-stage reads of R0-R7 see the pending write-back value, plus a retired-instruction counter and a sticky select-error flag.

Parameters:
- DATA_W, 16, data path width (matches DATA_BUS).
- ADDR_W, 3, general register address width (matches REG_ADDR_BUS, 8 registers).
- OP_W, 3, reg_op width (matches REG_OP_BUS; encodings REG_OP_NOP/REG/T/SP/IH/RA from define.v).

Ports:
- clk_50MHz  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous active-low reset.
- stall  in  1  hold MEM/WB register contents.
- flush  in  1  load a bubble instead of the incoming instruction.
- mem_valid  in  1  memory-stage instruction valid.
- mem_reg_op  in  OP_W  destination class of incoming instruction.
- mem_wb_addr  in  ADDR_W  destination general register index.
- mem_wb_sel  in  2  source select: 00 ALU, 01 memory, 10 PC+1, 11 illegal.
- mem_alu_data  in  DATA_W  ALU result.
- mem_rd_data  in  DATA_W  memory read data.
- mem_pc_next  in  DATA_W  PC+1 of the instruction (link value).
- dec_A_addr, dec_B_addr  in  ADDR_W  decode-stage register file read addresses.
- rf_A_data, rf_B_data  in  DATA_W  register file read data for those addresses.
- wb_valid  out  1  MEM/WB entry valid.
- wb_addr  out  ADDR_W  to register file.
- wb_data  out  DATA_W  to register file.
- reg_op  out  OP_W  to register file.
- A_fwd_data, B_fwd_data  out  DATA_W  bypassed operands to decode.
- fwd_A_hit, fwd_B_hit  out  1  bypass active.
- retire_cnt  out  16  retired-instruction count.
- sel_err  out  1  sticky illegal-select flag.

Behaviour:
- Reset (rst=0, async):
  - wb_valid=0, reg_op=REG_OP_NOP, wb_addr=0, wb_data=0, retire_cnt=0, sel_err=0.
  - The stage stays held while rst=0.
- Posedge update priority: flush > stall > capture.
  - flush=1: wb_valid<=0, reg_op<=REG_OP_NOP; wb_addr and wb_data hold.
  - stall=1, flush=0: all MEM/WB fields hold. The register file rewrites the same value each cycle; this is idempotent and required.
  - Capture:
    - wb_valid<=mem_valid.
    - reg_op<=(mem_valid ? mem_reg_op : REG_OP_NOP).
    - wb_addr<=mem_wb_addr.
    - wb_data<=mux(mem_wb_sel): 00 alu, 01 rd, 10 pc_next, 11 alu.
- Latency: one posedge from mem_* to wb_*; register file commit half a cycle later (negedge).
- reg_op is never non-NOP while wb_valid=0.
- sel_err: set at any capture with mem_valid=1 and mem_wb_sel=11; cleared only by reset.
- Bypass (combinational):
  - fwd_A_hit = wb_valid & (reg_op==REG_OP_REG) & (dec_A_addr==wb_addr).
  - A_fwd_data = fwd_A_hit ? wb_data : rf_A_data. B side identical.
  - T/SP/IH/RA writes never raise a hit.
- retire_cnt:
  - Increments at a posedge where wb_valid=1 and (stall=0 or flush=1), i.e. the current entry leaves WB.
  - Held entries are counted once. Wraps 0xFFFF -> 0x0000.
- Simultaneous flush and stall: flush wins; the departing valid entry still counts.
- Reset mid-stall or mid-write: async clear; no partial update survives.

Test Plan:
- Reset, then capture mem_valid=1, reg_op=REG_OP_REG, addr=3, sel=01, rd=0x1234 -> next cycle wb_valid=1, wb_addr=3, wb_data=0x1234; dec_A_addr=3 gives fwd_A_hit=1, A_fwd_data=0x1234; dec_B_addr=2 gives B_fwd_data=rf_B_data.
- sel=10, pc_next=0x00A1, reg_op=REG_OP_RA -> wb_data=0x00A1, reg_op=REG_OP_RA, fwd hits both 0 even when addresses match.
- Valid entry, then stall for 3 cycles, then release -> outputs constant during stall; retire_cnt advances by exactly 1.
- flush=1 and stall=1 with a valid incoming instruction -> wb_valid=0, reg_op=REG_OP_NOP; previous valid entry counted.
- Preload 0xFFFF retirements (or force) and retire one more -> retire_cnt=0x0000. Capture sel=11 valid -> wb_data=alu value, sel_err=1, persists until rst=0.
- Assert rst=0 mid-cycle while wb_valid=1 -> all outputs cleared immediately, without waiting for a clock edge.
